mem_stage: RTL and testbench

Memory-access stage directly downstream of the execution unit. It takes the execution unit's address, data, flags, write-back and stack controls through a valid/ready handshake. It performs the load or store on the data memory over a req/ack interface, owns the stack-pointer register, and presents one registered result per instruction to write-back. Instructions that do not access memory pass through with one cycle of latency.

---
 rtl/mem_stage.sv | 188 ++++++++++++++++++
 tb/tb_mem_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access stage: load/store over req/ack, stack pointer, write-back.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] SP_INIT = 'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [DATA_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  input  logic [3:0]        ex_flags,
  input  logic [2:0]        ex_wb_addr,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_sp_en,
  input  logic              ex_sp_op,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] sp_out,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [2:0]        wb_addr,
  output logic              wb_reg_write,
  output logic [3:0]        wb_flags
);

  localparam logic [DATA_W-1:0] SP_STEP = 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] sp_q, sp_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [2:0]        wb_addr_q, wb_addr_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [3:0]        wb_flags_q, wb_flags_d;
  // Instruction fields held while the memory access is outstanding
  logic              pend_read_q, pend_read_d;
  logic              pend_reg_write_q, pend_reg_write_d;
  logic [2:0]        pend_wb_addr_q, pend_wb_addr_d;
  logic [3:0]        pend_flags_q, pend_flags_d;
  logic              pend_sp_en_q, pend_sp_en_d;
  logic              pend_sp_op_q, pend_sp_op_d;

  logic accept;
  logic is_mem;

  always_comb begin
    accept           = in_valid && (state_q == IDLE) && !flush;
    is_mem           = ex_mem_read || ex_mem_write;
    state_d          = state_q;
    mem_req_d        = mem_req_q;
    mem_we_d         = mem_we_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    sp_d             = sp_q;
    wb_valid_d       = 1'b0;
    wb_data_d        = wb_data_q;
    wb_addr_d        = wb_addr_q;
    wb_reg_write_d   = wb_reg_write_q;
    wb_flags_d       = wb_flags_q;
    pend_read_d      = pend_read_q;
    pend_reg_write_d = pend_reg_write_q;
    pend_wb_addr_d   = pend_wb_addr_q;
    pend_flags_d     = pend_flags_q;
    pend_sp_en_d     = pend_sp_en_q;
    pend_sp_op_d     = pend_sp_op_q;

    case (state_q)
      IDLE: begin
        if (accept && is_mem) begin
          state_d          = WAIT;
          mem_req_d        = 1'b1;
          mem_we_d         = ex_mem_write;
          mem_addr_d       = ex_addr;
          mem_wdata_d      = ex_data;
          pend_read_d      = ex_mem_read && !ex_mem_write;
          pend_reg_write_d = ex_reg_write;
          pend_wb_addr_d   = ex_wb_addr;
          pend_flags_d     = ex_flags;
          pend_sp_en_d     = ex_sp_en;
          pend_sp_op_d     = ex_sp_op;
        end else if (accept) begin
          wb_valid_d     = 1'b1;
          wb_data_d      = ex_data;
          wb_addr_d      = ex_wb_addr;
          wb_reg_write_d = ex_reg_write;
          wb_flags_d     = ex_flags;
          if (ex_sp_en) begin
            sp_d = ex_sp_op ? sp_q + SP_STEP : sp_q - SP_STEP;
          end
        end
      end
      WAIT: begin
        // Flush is deliberately not looked at here: a started access always completes
        if (mem_ack) begin
          state_d        = IDLE;
          mem_req_d      = 1'b0;
          wb_valid_d     = 1'b1;
          wb_data_d      = pend_read_q ? mem_rdata : mem_wdata_q;
          wb_addr_d      = pend_wb_addr_q;
          wb_reg_write_d = pend_reg_write_q;
          wb_flags_d     = pend_flags_q;
          if (pend_sp_en_q) begin
            sp_d = pend_sp_op_q ? sp_q + SP_STEP : sp_q - SP_STEP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      mem_req_q        <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      sp_q             <= SP_INIT;
      wb_valid_q       <= 1'b0;
      wb_data_q        <= '0;
      wb_addr_q        <= '0;
      wb_reg_write_q   <= 1'b0;
      wb_flags_q       <= '0;
      pend_read_q      <= 1'b0;
      pend_reg_write_q <= 1'b0;
      pend_wb_addr_q   <= '0;
      pend_flags_q     <= '0;
      pend_sp_en_q     <= 1'b0;
      pend_sp_op_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      mem_req_q        <= mem_req_d;
      mem_we_q         <= mem_we_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      sp_q             <= sp_d;
      wb_valid_q       <= wb_valid_d;
      wb_data_q        <= wb_data_d;
      wb_addr_q        <= wb_addr_d;
      wb_reg_write_q   <= wb_reg_write_d;
      wb_flags_q       <= wb_flags_d;
      pend_read_q      <= pend_read_d;
      pend_reg_write_q <= pend_reg_write_d;
      pend_wb_addr_q   <= pend_wb_addr_d;
      pend_flags_q     <= pend_flags_d;
      pend_sp_en_q     <= pend_sp_en_d;
      pend_sp_op_q     <= pend_sp_op_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign sp_out       = sp_q;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_addr      = wb_addr_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_flags     = wb_flags_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed self-checking bench for mem_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, flush;
  logic [7:0] ex_addr, ex_data;
  logic [3:0] ex_flags;
  logic [2:0] ex_wb_addr;
  logic       ex_mem_read, ex_mem_write, ex_reg_write, ex_sp_en, ex_sp_op;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_ack;
  logic [7:0] sp_out;
  logic       wb_valid;
  logic [7:0] wb_data;
  logic [2:0] wb_addr;
  logic       wb_reg_write;
  logic [3:0] wb_flags;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage #(.DATA_W(8), .SP_INIT(8'hFF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .ex_addr(ex_addr), .ex_data(ex_data), .ex_flags(ex_flags), .ex_wb_addr(ex_wb_addr),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_sp_en(ex_sp_en), .ex_sp_op(ex_sp_op),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .sp_out(sp_out),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_addr(wb_addr),
    .wb_reg_write(wb_reg_write), .wb_flags(wb_flags)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; ex_addr = 0; ex_data = 0; ex_flags = 0; ex_wb_addr = 0;
    ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0; ex_sp_en = 0; ex_sp_op = 0;
  endtask

  task automatic offer(input logic [7:0] a, input logic [7:0] d, input logic [3:0] f,
                       input logic [2:0] wa, input logic rd, input logic wr,
                       input logic rw, input logic spe, input logic spo);
    in_valid = 1; ex_addr = a; ex_data = d; ex_flags = f; ex_wb_addr = wa;
    ex_mem_read = rd; ex_mem_write = wr; ex_reg_write = rw; ex_sp_en = spe; ex_sp_op = spo;
  endtask

  initial begin
    rst = 1; mem_ack = 0; mem_rdata = 0;
    idle_inputs();
    tick(); tick();
    chk("rst_sp", sp_out, 8'hFF);
    chk("rst_ready", in_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_wbd", wb_data, 0);
    chk("rst_addr", mem_addr, 0);
    rst = 0;

    // Non-memory pass-through
    offer(8'h00, 8'h15, 4'hA, 3'd3, 0, 0, 1, 0, 0);
    tick(); idle_inputs();
    chk("nm_wbv", wb_valid, 1);
    chk("nm_wbd", wb_data, 8'h15);
    chk("nm_wba", wb_addr, 3);
    chk("nm_wbrw", wb_reg_write, 1);
    chk("nm_flags", wb_flags, 4'hA);
    tick();
    chk("nm_pulse", wb_valid, 0);
    chk("nm_hold", wb_data, 8'h15);

    // Push with ack two cycles after req rises
    offer(8'hFF, 8'hAA, 4'h3, 3'd0, 0, 1, 0, 1, 0);
    tick(); idle_inputs();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ack = 1;
      chk("push_req", mem_req, 1);
      chk("push_we", mem_we, 1);
      chk("push_addr", mem_addr, 8'hFF);
      chk("push_wdata", mem_wdata, 8'hAA);
      chk("push_ready", in_ready, 0);
      chk("push_wbv", wb_valid, 0);
      chk("push_sp_hold", sp_out, 8'hFF);
      tick();
    end
    mem_ack = 0;
    chk("push_req_done", mem_req, 0);
    chk("push_ready_done", in_ready, 1);
    chk("push_sp", sp_out, 8'hFE);
    chk("push_wbv_done", wb_valid, 1);
    chk("push_wbd", wb_data, 8'hAA);
    chk("push_wbrw", wb_reg_write, 0);
    chk("push_flags", wb_flags, 4'h3);

    // Pop with immediate ack
    offer(8'hFF, 8'h00, 4'h0, 3'd5, 1, 0, 1, 1, 1);
    tick(); idle_inputs();
    mem_ack = 1; mem_rdata = 8'hAA;
    chk("pop_req", mem_req, 1);
    chk("pop_we", mem_we, 0);
    tick(); mem_ack = 0;
    chk("pop_wbv", wb_valid, 1);
    chk("pop_wbd", wb_data, 8'hAA);
    chk("pop_wbrw", wb_reg_write, 1);
    chk("pop_wba", wb_addr, 5);
    chk("pop_sp", sp_out, 8'hFF);

    // Pop again: SP wraps to 0x00
    offer(8'h00, 8'h00, 4'h0, 3'd6, 1, 0, 1, 1, 1);
    tick(); idle_inputs();
    mem_ack = 1; mem_rdata = 8'h5C;
    tick(); mem_ack = 0;
    chk("wrap_sp", sp_out, 8'h00);
    chk("wrap_wbd", wb_data, 8'h5C);

    // Flush in IDLE drops the offer
    offer(8'h20, 8'h99, 4'h0, 3'd1, 0, 1, 0, 1, 0);
    flush = 1;
    tick(); idle_inputs();
    chk("fl_req", mem_req, 0);
    chk("fl_wbv", wb_valid, 0);
    chk("fl_sp", sp_out, 8'h00);
    chk("fl_ready", in_ready, 1);

    // Flush during WAIT is ignored
    offer(8'h40, 8'h77, 4'h0, 3'd2, 0, 1, 0, 0, 0);
    tick(); idle_inputs();
    offer(8'h50, 8'h11, 4'h0, 3'd2, 0, 0, 1, 0, 0);
    flush = 1;
    chk("flw_req", mem_req, 1);
    tick();
    chk("flw_req2", mem_req, 1);
    chk("flw_addr", mem_addr, 8'h40);
    mem_ack = 1;
    tick(); mem_ack = 0; idle_inputs();
    chk("flw_wbv", wb_valid, 1);
    chk("flw_wbd", wb_data, 8'h77);

    // Read and write both set: write wins
    offer(8'h10, 8'h33, 4'h0, 3'd4, 1, 1, 0, 0, 0);
    tick(); idle_inputs();
    chk("rw_we", mem_we, 1);
    mem_ack = 1; mem_rdata = 8'hEE;
    tick(); mem_ack = 0;
    chk("rw_wbd", wb_data, 8'h33);

    // Back-to-back non-memory ops; the middle one pushes SP (0x00 -> 0xFF)
    offer(8'h00, 8'h01, 4'h1, 3'd1, 0, 0, 1, 0, 0);
    tick();
    chk("b2b1_wbv", wb_valid, 1);
    chk("b2b1_wbd", wb_data, 8'h01);
    offer(8'h00, 8'h02, 4'h2, 3'd2, 0, 0, 1, 1, 0);
    tick();
    chk("b2b2_wbv", wb_valid, 1);
    chk("b2b2_wbd", wb_data, 8'h02);
    chk("b2b2_sp", sp_out, 8'hFF);
    offer(8'h00, 8'h03, 4'h3, 3'd3, 0, 0, 1, 1, 1);
    tick(); idle_inputs();
    chk("b2b3_wbv", wb_valid, 1);
    chk("b2b3_wbd", wb_data, 8'h03);
    chk("b2b3_sp", sp_out, 8'h00);
    tick();
    chk("b2b_end", wb_valid, 0);

    // Reset while waiting abandons the access
    offer(8'h00, 8'h66, 4'h0, 3'd1, 0, 1, 0, 1, 0);
    tick(); idle_inputs();
    chk("rw_wait_req", mem_req, 1);
    rst = 1;
    tick(); rst = 0;
    mem_ack = 1;
    chk("rstw_req", mem_req, 0);
    chk("rstw_sp", sp_out, 8'hFF);
    chk("rstw_wbv", wb_valid, 0);
    chk("rstw_ready", in_ready, 1);
    tick(); mem_ack = 0;
    chk("rstw_late_ack", wb_valid, 0);
    chk("rstw_late_sp", sp_out, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
